// File: rtl/parity_pkg.sv
// Shared FSM encodings and parity-sense constants for the serial parity frame checker.
package parity_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } state_e;

  localparam logic PARITY_ODD  = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;

  // ones_xor covers data plus parity bit; a mismatch with the expected sense is an error.
  function automatic logic parity_mismatch(input logic ones_xor, input logic sense);
    return ones_xor ^ sense;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// Running XOR accumulator: synchronous clear has priority over the enabled XOR update.
module parity_accum (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic parity
);

  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (clear) begin
      parity_d = 1'b0;
    end else if (enable) begin
      parity_d = parity_q ^ bit_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;

endmodule

// File: rtl/parity_frame_checker.sv
// Receives start/data/parity/stop frames on bit strobes and hands each completed frame,
// with parity and stop-bit error flags, to a valid/ready consumer.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned ODD_PARITY = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 bit_en,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

  localparam int unsigned CntW  = $clog2(DATA_BITS + 1);
  localparam logic        Sense = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic acc_clear, acc_en, acc_parity;
  logic complete, load;

  parity_accum u_parity_accum (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (acc_clear),
    .enable  (acc_en),
    .bit_in  (serial_in),
    .parity  (acc_parity)
  );

  // Frame sequencing; nothing moves without a bit strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    complete  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bit_en && !serial_in) begin
          state_d   = StData;
          cnt_d     = '0;
          acc_clear = 1'b1;
        end
      end
      StData: begin
        if (bit_en) begin
          shift_d = {serial_in, shift_q[DATA_BITS-1:1]};
          acc_en  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntW'(DATA_BITS - 1)) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        // Parity bit folds into the same accumulator as the data bits.
        if (bit_en) begin
          acc_en  = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_en) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output holding register: a completed frame is dropped only if the previous one is stalled.
  always_comb begin
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = valid_q;
    load      = complete && (!valid_q || out_ready);
    overrun_d = complete && !load;
    if (load) begin
      data_d  = shift_q;
      perr_d  = parity_mismatch(acc_parity, Sense);
      ferr_d  = !serial_in;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign out_valid  = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (DATA_BITS=8, odd parity).
module tb_parity_frame_checker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       serial_in = 1'b1;
  logic       out_ready = 1'b1;
  logic [7:0] data_out;
  logic       parity_err, frame_err, out_valid, overrun;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  parity_frame_checker #(
    .DATA_BITS  (8),
    .ODD_PARITY (1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bit_en     (bit_en),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

  // Called just after a falling edge; the strobe is sampled on the following rising edge.
  task automatic strobe(input logic b, input int gap);
    serial_in = b;
    bit_en    = 1'b1;
    @(negedge clock);
    bit_en    = 1'b0;
    serial_in = 1'b1;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap,
                            input logic rdy_stop);
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
    strobe(p, gap);
    out_ready = rdy_stop;
    strobe(s, 0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++; if ({data_out, parity_err, frame_err, out_valid, overrun} !== 12'h000) begin
      failures++; $display("FAIL reset_outputs got=%h exp=000",
                           {data_out, parity_err, frame_err, out_valid, overrun});
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_idle;
    for (int i = 0; i < 3; i++) strobe(1'b1, 0);
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL idle_no_frame got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_good;
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL good_pre_valid got=%b exp=0", out_valid);
    end
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin
      failures++; $display("FAIL good_valid got=%b exp=1", out_valid);
    end
    checks++; if ({data_out, parity_err, frame_err} !== {8'hA5, 2'b00}) begin
      failures++; $display("FAIL good_frame got=%h/%b/%b exp=a5/0/0", data_out, parity_err,
                           frame_err);
    end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL good_consumed got=%b exp=0", out_valid);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_parity_err;
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b1);
    checks++; if ({out_valid, data_out, parity_err, frame_err} !== {1'b1, 8'hA5, 2'b10}) begin
      failures++; $display("FAIL parity_err got=%b/%h/%b/%b exp=1/a5/1/0", out_valid, data_out,
                           parity_err, frame_err);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b1);
    checks++; if ({out_valid, data_out, parity_err, frame_err} !== {1'b1, 8'h3C, 2'b01}) begin
      failures++; $display("FAIL frame_err got=%b/%h/%b/%b exp=1/3c/0/1", out_valid, data_out,
                           parity_err, frame_err);
    end
    @(negedge clock);
    send_frame(8'h01, 1'b0, 1'b1, 0, 1'b1);
    checks++; if ({out_valid, data_out, parity_err, frame_err} !== {1'b1, 8'h01, 2'b00}) begin
      failures++; $display("FAIL frame_err_next got=%b/%h/%b/%b exp=1/01/0/0", out_valid,
                           data_out, parity_err, frame_err);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_overrun;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 0, 1'b0);
    checks++; if ({out_valid, data_out, overrun} !== {1'b1, 8'h11, 1'b0}) begin
      failures++; $display("FAIL ovr_first got=%b/%h/%b exp=1/11/0", out_valid, data_out,
                           overrun);
    end
    send_frame(8'h22, 1'b1, 1'b1, 0, 1'b0);
    checks++; if ({out_valid, data_out, overrun} !== {1'b1, 8'h11, 1'b1}) begin
      failures++; $display("FAIL ovr_pulse got=%b/%h/%b exp=1/11/1", out_valid, data_out,
                           overrun);
    end
    @(negedge clock);
    checks++; if ({out_valid, data_out, overrun} !== {1'b1, 8'h11, 1'b0}) begin
      failures++; $display("FAIL ovr_single got=%b/%h/%b exp=1/11/0", out_valid, data_out,
                           overrun);
    end
    out_ready = 1'b1;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL ovr_release got=%b exp=0", out_valid);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_back_to_back;
    send_frame(8'hA5, 1'b1, 1'b1, 2, 1'b1);
    checks++; if ({out_valid, data_out, parity_err, frame_err} !== {1'b1, 8'hA5, 2'b00}) begin
      failures++; $display("FAIL slow_good got=%b/%h/%b/%b exp=1/a5/0/0", out_valid, data_out,
                           parity_err, frame_err);
    end
    repeat (2) @(negedge clock);
    send_frame(8'h3C, 1'b1, 1'b0, 2, 1'b1);
    checks++; if ({out_valid, data_out, parity_err, frame_err} !== {1'b1, 8'h3C, 2'b01}) begin
      failures++; $display("FAIL slow_ferr got=%b/%h/%b/%b exp=1/3c/0/1", out_valid, data_out,
                           parity_err, frame_err);
    end
    repeat (2) @(negedge clock);
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 0, 1'b1);
    checks++; if ({out_valid, data_out, overrun} !== {1'b1, 8'h22, 1'b0}) begin
      failures++; $display("FAIL coincide_load got=%b/%h/%b exp=1/22/0", out_valid, data_out,
                           overrun);
    end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL coincide_clear got=%b exp=0", out_valid);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_mid_reset;
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(1'b1, 0);
    reset_n = 1'b0;
    #1;
    checks++; if ({data_out, parity_err, frame_err, out_valid, overrun} !== 12'h000) begin
      failures++; $display("FAIL midreset_outputs got=%h exp=000",
                           {data_out, parity_err, frame_err, out_valid, overrun});
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if ({out_valid, overrun} !== 2'b00) begin
      failures++; $display("FAIL midreset_quiet got=%b exp=00", {out_valid, overrun});
    end
    send_frame(8'h5A, 1'b1, 1'b1, 0, 1'b1);
    checks++; if ({out_valid, data_out, parity_err, frame_err} !== {1'b1, 8'h5A, 2'b00}) begin
      failures++; $display("FAIL midreset_next got=%b/%h/%b/%b exp=1/5a/0/0", out_valid,
                           data_out, parity_err, frame_err);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_good();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame (2..16).
REQ-002 Parameter ODD_PARITY, default 1; 1 = odd parity (data plus parity bit hold an odd count of ones), 0 = even.
REQ-003 Port clock  in  1  single clock; all state changes on rising edge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port bit_en  in  1  bit strobe; serial_in is sampled only in cycles where bit_en=1.
REQ-006 Port serial_in  in  1  serial line, idle high.
REQ-007 Port data_out  out  DATA_BITS  received data word, LSB first on the line.
REQ-008 Port parity_err  out  1  parity mismatch flag for the frame in data_out.
REQ-009 Port frame_err  out  1  stop-bit error flag for the frame in data_out.
REQ-010 Port out_valid  out  1  data_out and both error flags hold a valid frame.
REQ-011 Port out_ready  in  1  consumer accepts the frame when out_valid=1 and out_ready=1.
REQ-012 Port overrun  out  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-013 Frame format SHALL be: start bit (0), DATA_BITS data bits LSB first, parity bit, stop bit (1), each one bit_en strobe.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP; when bit_en=0 the FSM and datapath SHALL hold state.
REQ-015 IDLE -> DATA on bit_en with serial_in=0; bit counter cleared; parity accumulator cleared; serial_in=1 stays in IDLE.
REQ-016 DATA: each bit_en shifts serial_in into the shift register and XORs it into the accumulator; after DATA_BITS strobes -> PARITY.
REQ-017 PARITY: on bit_en, capture the parity bit -> STOP.
REQ-018 parity_err SHALL be 1 when (XOR of data bits XOR parity bit) differs from ODD_PARITY.
REQ-019 STOP: on bit_en, frame_err = NOT serial_in; the frame completes -> IDLE regardless of stop-bit value.
REQ-020 Completion SHALL load data_out, parity_err and frame_err when out_valid=0 or out_ready=1 in that cycle; out_valid=1 from the next cycle (latency 1 clock after the stop strobe).
REQ-021 Completion while out_valid=1 and out_ready=0 SHALL drop the new frame, keep outputs unchanged, and pulse overrun for exactly one cycle.
REQ-022 out_ready=1 with out_valid=1 and no simultaneous load SHALL clear out_valid next cycle; a simultaneous load keeps out_valid=1 with the new frame.
REQ-023 data_out and the flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 A frame with errors SHALL still be delivered through the handshake, with its flags set.
REQ-025 The line SHALL not be re-checked for idle after a stop error; a low line in IDLE starts a new frame.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, counter=0, shift register=0, accumulator=0, data_out=0, parity_err=0, frame_err=0, out_valid=0, overrun=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; no output, no overrun.

Structure
REQ-028 Shared package parity_pkg SHALL hold the FSM state encodings and the PARITY_ODD/PARITY_EVEN constants.
REQ-029 Sub-module parity_accum (clearable, enabled running XOR, 1-bit state) SHALL implement the accumulator; all other logic stays in parity_frame_checker.
REQ-030 Target implementation size is 120-400 lines of RTL.

Verification (DATA_BITS=8, ODD_PARITY=1, out_ready=1 unless stated)
REQ-031 Send 0xA5, parity 1, stop 1 -> data_out=0xA5, parity_err=0, frame_err=0, out_valid rises 1 clock after the stop strobe.
REQ-032 Send 0xA5, parity 0, stop 1 -> data_out=0xA5, parity_err=1, frame_err=0.
REQ-033 Send 0x3C, parity 1, stop 0 -> data_out=0x3C, frame_err=1, parity_err=0; the next frame 0x01 (parity 0) is received correctly.
REQ-034 Hold out_ready=0; send 0x11 then 0x22 -> data_out stays 0x11, one overrun pulse at the 0x22 stop; raising out_ready clears out_valid next cycle.
REQ-035 Pull reset_n low after 4 data bits -> all outputs 0 immediately; the following frame 0x5A (parity 1) yields data_out=0x5A with no errors.
REQ-036 Send the same frames with bit_en every cycle and every 3rd cycle -> identical results; load coinciding with out_ready=1 keeps out_valid=1 with the new data.
